// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_pkg
// Shared state encoding, low-power mode codes and width default for SPI.
// Rev    : 1.0
// ============================================================================
package spi_pkg;

  localparam int c_DATA_W = 8;

  localparam logic [1:0] c_MODE_RUN  = 2'b00;
  localparam logic [1:0] c_MODE_WAIT = 2'b01;
  localparam logic [1:0] c_MODE_STOP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } spi_state_t;

  // Stop mode and the reserved 2'b11 code both fall through to inactive.
  function automatic logic spi_active(input logic       spe,
                                      input logic       mstr,
                                      input logic [1:0] mode,
                                      input logic       spiswai);
    return spe & mstr &
           ((mode == c_MODE_RUN) | ((mode == c_MODE_WAIT) & ~spiswai));
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_transfer_controller_if.sv
`default_nettype none
// ============================================================================
// Module : spi_transfer_controller_if
// Control, strobe and serial-data bundle of the SPI transfer controller.
// Rev    : 1.0
// ============================================================================
interface spi_transfer_controller_if #(
  parameter int DATA_W = spi_pkg::c_DATA_W
);

  logic              spe_i;
  logic              mstr_i;
  logic [1:0]        spi_mode_i;
  logic              spiswai_i;
  logic              send_data_i;
  logic              lsbfe_i;
  logic [DATA_W-1:0] data_mosi_i;
  logic              mosi_send_sclk_i;
  logic              miso_recieve_sclk_i;
  logic              miso_i;
  logic              ss_o;
  logic              mosi_o;
  logic [DATA_W-1:0] receive_data_o;
  logic              rx_valid_o;
  logic              busy_o;

  modport master (
    input  spe_i, mstr_i, spi_mode_i, spiswai_i, send_data_i, lsbfe_i,
           data_mosi_i, mosi_send_sclk_i, miso_recieve_sclk_i, miso_i,
    output ss_o, mosi_o, receive_data_o, rx_valid_o, busy_o
  );

  modport slave (
    output spe_i, mstr_i, spi_mode_i, spiswai_i, send_data_i, lsbfe_i,
           data_mosi_i, mosi_send_sclk_i, miso_recieve_sclk_i, miso_i,
    input  ss_o, mosi_o, receive_data_o, rx_valid_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module : spi_shift_reg
// DATA_W shift register, LSB- or MSB-first, with parallel load and shift-in.
// Rev    : 1.0
// ============================================================================
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  wire               PCLK,
  input  wire               PRESET,
  input  wire               i_load,
  input  wire  [DATA_W-1:0] i_load_data,
  input  wire               i_shift,
  input  wire               i_shift_in,
  input  wire               i_lsbfe,
  output logic [DATA_W-1:0] o_data,
  output logic              o_out_bit
);

  logic [DATA_W-1:0] r_data;

  // The outgoing end is the bit about to leave; new bits enter the far end.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      if (i_lsbfe) begin
        r_data <= {i_shift_in, r_data[DATA_W-1:1]};
      end else begin
        r_data <= {r_data[DATA_W-2:0], i_shift_in};
      end
    end
  end

  assign o_data    = r_data;
  assign o_out_bit = i_lsbfe ? r_data[0] : r_data[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/spi_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module : spi_transfer_controller
// Master-side SPI byte sequencer: start, shift on baud strobes, return byte.
// Rev    : 1.0
// ============================================================================
module spi_transfer_controller
  import spi_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int SS_GAP = 2
) (
  input wire PCLK,
  input wire PRESET,
  spi_transfer_controller_if.master bus
);

  localparam int c_CNT_W = $clog2(DATA_W) + 1;
  localparam int c_GAP_W = (SS_GAP > 0) ? $clog2(SS_GAP + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_W);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(SS_GAP);

  spi_state_t         r_state;
  spi_state_t         w_next_state;
  logic [c_CNT_W-1:0] r_tx_cnt;
  logic [c_CNT_W-1:0] r_rx_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic               r_lsbfe;
  logic [DATA_W-1:0]  r_receive_data;

  logic               w_active;
  logic               w_start;
  logic               w_abort;
  logic               w_tx_adv;
  logic               w_rx_smp;
  logic               w_finish;
  logic               w_tx_out;
  logic [DATA_W-1:0]  w_rx_data;
  logic [DATA_W-1:0]  w_unused_tx_data;
  logic               w_unused_rx_out;

  assign w_active = spi_active(bus.spe_i, bus.mstr_i, bus.spi_mode_i,
                               bus.spiswai_i);
  assign w_start  = (r_state == ST_IDLE) & bus.send_data_i & w_active &
                    (r_gap_cnt == '0);
  assign w_abort  = ~bus.spe_i & ((r_state == ST_LOAD) | (r_state == ST_SHIFT));
  // w_active already folds in spe_i, so a paused or aborted cycle moves nothing.
  assign w_tx_adv = (r_state == ST_SHIFT) & w_active & bus.mosi_send_sclk_i &
                    (r_tx_cnt < c_CNT_FULL);
  assign w_rx_smp = (r_state == ST_SHIFT) & w_active & bus.miso_recieve_sclk_i &
                    (r_rx_cnt < c_CNT_FULL);
  assign w_finish = (r_state == ST_SHIFT) & (w_next_state == ST_DONE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (!bus.spe_i)    w_next_state = ST_IDLE;
        else if (w_active) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!bus.spe_i)                            w_next_state = ST_IDLE;
        else if (w_active && r_rx_cnt == c_CNT_FULL) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ss_o       = 1'b1;
    bus.busy_o     = 1'b0;
    bus.rx_valid_o = 1'b0;
    case (r_state)
      ST_LOAD, ST_SHIFT: begin
        bus.ss_o   = 1'b0;
        bus.busy_o = 1'b1;
      end
      ST_DONE: begin
        bus.busy_o     = 1'b1;
        bus.rx_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // The gap is armed on entry to DONE so that DONE itself counts as gap time.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      r_gap_cnt      <= '0;
      r_lsbfe        <= 1'b0;
      r_receive_data <= '0;
    end else if (w_abort) begin
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_start) begin
        r_tx_cnt <= c_CNT_W'(1);
        r_rx_cnt <= '0;
        r_lsbfe  <= bus.lsbfe_i;
      end else begin
        if (w_tx_adv) r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
        if (w_rx_smp) r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
      end
      if (w_finish) begin
        r_receive_data <= w_rx_data;
        r_gap_cnt      <= c_GAP_LOAD;
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
      end
    end
  end

  spi_shift_reg #(.DATA_W(DATA_W)) u_tx_sr (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .i_load      (w_start),
    .i_load_data (bus.data_mosi_i),
    .i_shift     (w_tx_adv),
    .i_shift_in  (1'b0),
    .i_lsbfe     (r_lsbfe),
    .o_data      (w_unused_tx_data),
    .o_out_bit   (w_tx_out)
  );

  spi_shift_reg #(.DATA_W(DATA_W)) u_rx_sr (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .i_load      (w_start),
    .i_load_data ({DATA_W{1'b0}}),
    .i_shift     (w_rx_smp),
    .i_shift_in  (bus.miso_i),
    .i_lsbfe     (r_lsbfe),
    .o_data      (w_rx_data),
    .o_out_bit   (w_unused_rx_out)
  );

  assign bus.mosi_o         = w_tx_out;
  assign bus.receive_data_o = r_receive_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_transfer_controller
// Directed self-checking bench for the SPI transfer controller.
// Rev    : 1.0
// ============================================================================
module tb_spi_transfer_controller;
  import spi_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_transfer_controller_if #(.DATA_W(8)) bus ();

  spi_transfer_controller #(.DATA_W(8), .SS_GAP(2)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.master)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic start_xfer(input logic [7:0] data, input logic lsb, input bit hold);
    bus.data_mosi_i = data;
    bus.lsbfe_i     = lsb;
    bus.send_data_i = 1'b1;
    step();
    if (!hold) bus.send_data_i = 1'b0;
    step();
  endtask

  // Drives receive-then-send strobe pairs for bit positions lo..hi.
  task automatic shift_byte(input logic [7:0] pat, input logic lsb, input bit loop,
                            input bit noisy, input int lo, input int hi,
                            output logic [7:0] seq, output int ss_high);
    seq = 8'h00;
    ss_high = 0;
    for (int i = lo; i <= hi; i++) begin
      seq = {seq[6:0], bus.mosi_o};
      if (bus.ss_o !== 1'b0) ss_high++;
      bus.miso_i = loop ? bus.mosi_o : (lsb ? pat[i] : pat[7-i]);
      bus.miso_recieve_sclk_i = 1'b1;
      if (noisy) bus.send_data_i = 1'b1;
      step();
      bus.miso_recieve_sclk_i = 1'b0;
      if (noisy) bus.send_data_i = 1'b0;
      if (bus.ss_o !== 1'b0) ss_high++;
      bus.mosi_send_sclk_i = 1'b1;
      step();
      bus.mosi_send_sclk_i = 1'b0;
    end
  endtask

  task automatic wait_valid(output int vcnt, output logic [7:0] vdata);
    vcnt = 0;
    vdata = 8'hxx;
    for (int i = 0; i < 4; i++) begin
      if (bus.rx_valid_o === 1'b1) begin
        vcnt++;
        vdata = bus.receive_data_o;
      end
      step();
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    step();
    step();
    n_checks++; if (bus.ss_o !== 1'b1) begin n_fail++; $display("FAIL reset_ss: got %b want 1", bus.ss_o); end
    n_checks++; if (bus.mosi_o !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", bus.mosi_o); end
    n_checks++; if (bus.receive_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", bus.receive_data_o); end
    n_checks++; if (bus.rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    PRESET = 1'b0;
    step();
  endtask

  task automatic test_msb_loopback();
    logic [7:0] seq, vd;
    int h, vc;
    start_xfer(8'hA5, 1'b0, 1'b0);
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL msb_busy: got %b want 1", bus.busy_o); end
    shift_byte(8'h00, 1'b0, 1'b1, 1'b0, 0, 7, seq, h);
    wait_valid(vc, vd);
    n_checks++; if (seq !== 8'hA5) begin n_fail++; $display("FAIL msb_mosi_seq: got %h want a5", seq); end
    n_checks++; if (h !== 0) begin n_fail++; $display("FAIL msb_ss_low: got %0d high samples want 0", h); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL msb_valid_cnt: got %0d want 1", vc); end
    n_checks++; if (vd !== 8'hA5) begin n_fail++; $display("FAIL msb_rdata: got %h want a5", vd); end
    n_checks++; if (bus.ss_o !== 1'b1) begin n_fail++; $display("FAIL msb_ss_after: got %b want 1", bus.ss_o); end
    n_checks++; if (bus.mosi_o !== 1'b1) begin n_fail++; $display("FAIL msb_mosi_hold: got %b want 1", bus.mosi_o); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq, vd;
    int h, vc;
    bus.spi_mode_i = c_MODE_WAIT;
    bus.spiswai_i  = 1'b0;
    start_xfer(8'h01, 1'b1, 1'b0);
    shift_byte(8'h3C, 1'b1, 1'b0, 1'b0, 0, 7, seq, h);
    wait_valid(vc, vd);
    bus.spi_mode_i = c_MODE_RUN;
    n_checks++; if (seq !== 8'h80) begin n_fail++; $display("FAIL lsb_mosi_seq: got %h want 80", seq); end
    n_checks++; if (vd !== 8'h3C) begin n_fail++; $display("FAIL lsb_rdata: got %h want 3c", vd); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL lsb_valid_cnt: got %0d want 1", vc); end
    n_checks++; if (bus.mosi_o !== 1'b0) begin n_fail++; $display("FAIL lsb_mosi_hold: got %b want 0", bus.mosi_o); end
  endtask

  task automatic test_wait_pause();
    logic [7:0] sa, sb, vd;
    int h1, h2, vc, ss_bad, busy_bad, mosi_bad;
    ss_bad = 0; busy_bad = 0; mosi_bad = 0;
    start_xfer(8'h5A, 1'b0, 1'b0);
    shift_byte(8'hC3, 1'b0, 1'b0, 1'b0, 0, 2, sa, h1);
    bus.spi_mode_i = c_MODE_WAIT;
    bus.spiswai_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.mosi_send_sclk_i    = 1'b1;
      bus.miso_recieve_sclk_i = 1'b1;
      bus.miso_i = (i % 2 == 1);
      step();
      if (bus.ss_o !== 1'b0) ss_bad++;
      if (bus.busy_o !== 1'b1) busy_bad++;
      if (bus.mosi_o !== 1'b1) mosi_bad++;
    end
    bus.mosi_send_sclk_i    = 1'b0;
    bus.miso_recieve_sclk_i = 1'b0;
    bus.spi_mode_i = c_MODE_RUN;
    bus.spiswai_i  = 1'b0;
    shift_byte(8'hC3, 1'b0, 1'b0, 1'b0, 3, 7, sb, h2);
    wait_valid(vc, vd);
    n_checks++; if (ss_bad !== 0) begin n_fail++; $display("FAIL pause_ss: got %0d high cycles want 0", ss_bad); end
    n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL pause_busy: got %0d idle cycles want 0", busy_bad); end
    n_checks++; if (mosi_bad !== 0) begin n_fail++; $display("FAIL pause_mosi: got %0d moved cycles want 0", mosi_bad); end
    n_checks++; if ({sa[2:0], sb[4:0]} !== 8'h5A) begin n_fail++; $display("FAIL pause_mosi_seq: got %h want 5a", {sa[2:0], sb[4:0]}); end
    n_checks++; if (h1 + h2 !== 0) begin n_fail++; $display("FAIL pause_ss_low: got %0d want 0", h1 + h2); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL pause_valid_cnt: got %0d want 1", vc); end
    n_checks++; if (vd !== 8'hC3) begin n_fail++; $display("FAIL pause_rdata: got %h want c3", vd); end
  endtask

  task automatic test_abort();
    logic [7:0] seq, vd;
    int h, vc;
    start_xfer(8'hF0, 1'b0, 1'b0);
    shift_byte(8'hFF, 1'b0, 1'b0, 1'b0, 0, 3, seq, h);
    bus.spe_i = 1'b0;
    step();
    n_checks++; if (bus.ss_o !== 1'b1) begin n_fail++; $display("FAIL abort_ss: got %b want 1", bus.ss_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy_o); end
    n_checks++; if (bus.rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", bus.rx_valid_o); end
    n_checks++; if (bus.receive_data_o !== 8'hC3) begin n_fail++; $display("FAIL abort_rdata: got %h want c3", bus.receive_data_o); end
    n_checks++; if (bus.mosi_o !== 1'b0) begin n_fail++; $display("FAIL abort_mosi_hold: got %b want 0", bus.mosi_o); end
    bus.spe_i = 1'b1;
    wait_valid(vc, vd);
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL abort_late_valid: got %0d want 0", vc); end
  endtask

  task automatic test_inactive_modes();
    int bad_stop, bad_rsvd, bad_slave;
    bad_stop = 0; bad_rsvd = 0; bad_slave = 0;
    bus.send_data_i = 1'b1;
    bus.spi_mode_i  = c_MODE_STOP;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.busy_o !== 1'b0 || bus.ss_o !== 1'b1) bad_stop++;
    end
    bus.spi_mode_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.busy_o !== 1'b0 || bus.ss_o !== 1'b1) bad_rsvd++;
    end
    bus.spi_mode_i = c_MODE_RUN;
    bus.mstr_i     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.busy_o !== 1'b0 || bus.ss_o !== 1'b1) bad_slave++;
    end
    bus.send_data_i = 1'b0;
    bus.mstr_i      = 1'b1;
    step();
    n_checks++; if (bad_stop !== 0) begin n_fail++; $display("FAIL stop_mode_start: got %0d active cycles want 0", bad_stop); end
    n_checks++; if (bad_rsvd !== 0) begin n_fail++; $display("FAIL mode11_start: got %0d active cycles want 0", bad_rsvd); end
    n_checks++; if (bad_slave !== 0) begin n_fail++; $display("FAIL slave_start: got %0d active cycles want 0", bad_slave); end
  endtask

  task automatic test_send_ignored();
    logic [7:0] seq, vd;
    int h, vc;
    start_xfer(8'h96, 1'b0, 1'b0);
    shift_byte(8'h00, 1'b0, 1'b1, 1'b1, 0, 7, seq, h);
    wait_valid(vc, vd);
    n_checks++; if (seq !== 8'h96) begin n_fail++; $display("FAIL ign_mosi_seq: got %h want 96", seq); end
    n_checks++; if (h !== 0) begin n_fail++; $display("FAIL ign_ss_low: got %0d want 0", h); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL ign_valid_cnt: got %0d want 1", vc); end
    n_checks++; if (vd !== 8'h96) begin n_fail++; $display("FAIL ign_rdata: got %h want 96", vd); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_restart: got busy %b want 0", bus.busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s1, s2, d1, vd;
    int h1, h2, gap, v1, vc;
    gap = 0; v1 = 0; d1 = 8'hxx;
    start_xfer(8'h3C, 1'b0, 1'b1);
    bus.data_mosi_i = 8'hE1;
    shift_byte(8'h96, 1'b0, 1'b0, 1'b0, 0, 7, s1, h1);
    while (bus.ss_o === 1'b1 && gap < 20) begin
      if (bus.rx_valid_o === 1'b1) begin
        v1++;
        d1 = bus.receive_data_o;
      end
      gap++;
      step();
    end
    bus.send_data_i = 1'b0;
    step();
    shift_byte(8'h69, 1'b0, 1'b0, 1'b0, 0, 7, s2, h2);
    wait_valid(vc, vd);
    n_checks++; if (s1 !== 8'h3C) begin n_fail++; $display("FAIL b2b_seq1: got %h want 3c", s1); end
    n_checks++; if (h1 !== 0) begin n_fail++; $display("FAIL b2b_ss_low1: got %0d want 0", h1); end
    n_checks++; if (v1 !== 1) begin n_fail++; $display("FAIL b2b_valid1: got %0d want 1", v1); end
    n_checks++; if (d1 !== 8'h96) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 96", d1); end
    n_checks++; if (gap !== 3) begin n_fail++; $display("FAIL b2b_ss_gap: got %0d cycles want 3", gap); end
    n_checks++; if (s2 !== 8'hE1) begin n_fail++; $display("FAIL b2b_seq2: got %h want e1", s2); end
    n_checks++; if (h2 !== 0) begin n_fail++; $display("FAIL b2b_ss_low2: got %0d want 0", h2); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL b2b_valid2: got %0d want 1", vc); end
    n_checks++; if (vd !== 8'h69) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 69", vd); end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] seq, vd;
    int h, vc;
    start_xfer(8'hFF, 1'b0, 1'b0);
    shift_byte(8'h00, 1'b0, 1'b0, 1'b0, 0, 2, seq, h);
    #2;
    PRESET = 1'b1;
    #1;
    n_checks++; if (bus.ss_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ss: got %b want 1", bus.ss_o); end
    n_checks++; if (bus.mosi_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mosi: got %b want 0", bus.mosi_o); end
    n_checks++; if (bus.receive_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 00", bus.receive_data_o); end
    n_checks++; if (bus.rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", bus.rx_valid_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy_o); end
    step();
    step();
    PRESET = 1'b0;
    step();
    start_xfer(8'hFF, 1'b0, 1'b0);
    shift_byte(8'h00, 1'b0, 1'b1, 1'b0, 0, 7, seq, h);
    wait_valid(vc, vd);
    n_checks++; if (seq !== 8'hFF) begin n_fail++; $display("FAIL rst_after_seq: got %h want ff", seq); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL rst_after_valid: got %0d want 1", vc); end
    n_checks++; if (vd !== 8'hFF) begin n_fail++; $display("FAIL rst_after_rdata: got %h want ff", vd); end
  endtask

  initial begin
    PRESET                  = 1'b1;
    bus.spe_i               = 1'b1;
    bus.mstr_i              = 1'b1;
    bus.spi_mode_i          = c_MODE_RUN;
    bus.spiswai_i           = 1'b0;
    bus.send_data_i         = 1'b0;
    bus.lsbfe_i             = 1'b0;
    bus.data_mosi_i         = 8'h00;
    bus.mosi_send_sclk_i    = 1'b0;
    bus.miso_recieve_sclk_i = 1'b0;
    bus.miso_i              = 1'b0;
    test_reset();
    test_msb_loopback();
    test_lsb_first();
    test_wait_pause();
    test_abort();
    test_inactive_modes();
    test_send_ignored();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
